// File: rtl/tile_match_pkg.sv
// Shared types and constants for the tile-matching in-game core.
// Board layout, value width and FSM state encoding live here.
package tile_match_pkg;

    localparam int BOARD_TILES = 16;
    localparam int NUM_PAIRS   = 8;
    localparam int VAL_W       = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PICK1   = 3'd1,
        PICK2   = 3'd2,
        COMPARE = 3'd3,
        SHOW    = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Index 0 sits in the least significant slot.
    localparam logic [BOARD_TILES*VAL_W-1:0] LAYOUT = {
        3'd5, 3'd2, 3'd6, 3'd0, 3'd7, 3'd4, 3'd3, 3'd1,
        3'd4, 3'd6, 3'd2, 3'd7, 3'd1, 3'd5, 3'd0, 3'd3
    };

    function automatic logic [VAL_W-1:0] tile_val(input logic [3:0] pos);
        return LAYOUT[pos*VAL_W +: VAL_W];
    endfunction

endpackage

// File: rtl/match_delay_timer.sv
// Loadable down-counter that holds a mismatched pair face-up.
// Stops at zero; zero is a level flag.
module match_delay_timer #(
    parameter int CYCLES = 25000000,
    parameter int W      = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/tile_match_engine.sv
// In-game core: 4x4 board, cursor, pick/compare FSM and scoring.
// Define MOVE_LIMIT_EN for a move limit and the extra won output.
module tile_match_engine
    import tile_match_pkg::*;
#(
    parameter int MISMATCH_CYCLES = 25000000,
    parameter int MOVES_W         = 8
`ifdef MOVE_LIMIT_EN
    , parameter int MAX_MOVES     = 40
`endif
) (
    input  logic               CLOCK_50,
    input  logic               userquit,
    input  logic               ingameOn,
    input  logic               key_up,
    input  logic               key_down,
    input  logic               key_left,
    input  logic               key_right,
    input  logic               key_select,
    input  logic [3:0]         query_idx,
    output logic [VAL_W-1:0]   query_val,
    output logic [3:0]         cursor,
    output logic [15:0]        revealed,
    output logic [15:0]        matched,
    output logic [MOVES_W-1:0] moves,
    output logic               gameOver
`ifdef MOVE_LIMIT_EN
    , output logic             won
`endif
);

    localparam int TMR_W = (MISMATCH_CYCLES > 1) ? $clog2(MISMATCH_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MISMATCH_CYCLES - 1);
    localparam logic [3:0] ALL_PAIRS = 4'(NUM_PAIRS);

    state_t state, state_n;
    logic [3:0] free_cnt, offset, offset_n;
    logic [3:0] first_idx, first_n, second_idx, second_n;
    logic [3:0] pairs, pairs_n, cursor_n;
    logic [15:0] revealed_n, matched_n, pick_mask;
    logic [MOVES_W-1:0] moves_n;
    logic game_over_n, tmr_load, tmr_zero;
    logic free_tile, pair_eq, in_play, limit_hit;
    logic [1:0] row, col;
`ifdef MOVE_LIMIT_EN
    localparam logic [MOVES_W-1:0] MOVE_CAP = MOVES_W'(MAX_MOVES);
    logic won_n;
    assign limit_hit = (moves >= MOVE_CAP);
`else
    assign limit_hit = 1'b0;
`endif

    assign row       = cursor[3:2];
    assign col       = cursor[1:0];
    assign free_tile = !matched[cursor] && !revealed[cursor];
    assign pair_eq   = tile_val(first_idx + offset) == tile_val(second_idx + offset);
    assign query_val = tile_val(query_idx + offset);
    assign in_play   = (state == PICK1) || (state == PICK2) ||
                       (state == COMPARE) || (state == SHOW);
    assign pick_mask = (16'd1 << first_idx) | (16'd1 << second_idx);

    match_delay_timer #(.CYCLES(MISMATCH_CYCLES), .W(TMR_W)) u_timer (
        .clk      (CLOCK_50),
        .rst      (userquit),
        .load     (tmr_load),
        .load_val (TMR_LOAD),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_n     = state;
        cursor_n    = cursor;
        revealed_n  = revealed;
        matched_n   = matched;
        moves_n     = moves;
        pairs_n     = pairs;
        first_n     = first_idx;
        second_n    = second_idx;
        offset_n    = offset;
        game_over_n = gameOver;
        tmr_load    = 1'b0;
`ifdef MOVE_LIMIT_EN
        won_n       = won;
`endif
        // Moves wrap inside their own row or column.
        if (in_play) begin
            priority case (1'b1)
                key_up:    cursor_n = {row - 2'd1, col};
                key_down:  cursor_n = {row + 2'd1, col};
                key_left:  cursor_n = {row, col - 2'd1};
                key_right: cursor_n = {row, col + 2'd1};
                default:   cursor_n = cursor;
            endcase
        end
        unique case (state)
            IDLE: begin
                if (ingameOn) begin
                    offset_n   = free_cnt;
                    cursor_n   = '0;
                    revealed_n = '0;
                    matched_n  = '0;
                    moves_n    = '0;
                    pairs_n    = '0;
                    first_n    = '0;
                    state_n    = PICK1;
                end
            end
            PICK1: begin
                if (key_select && free_tile) begin
                    revealed_n[cursor] = 1'b1;
                    first_n = cursor;
                    state_n = PICK2;
                end
            end
            PICK2: begin
                if (key_select && free_tile && cursor != first_idx) begin
                    revealed_n[cursor] = 1'b1;
                    second_n = cursor;
                    if (moves != '1)
                        moves_n = moves + 1'b1;
                    state_n = COMPARE;
                end
            end
            COMPARE: begin
                if (pair_eq) begin
                    matched_n  = matched | pick_mask;
                    revealed_n = revealed & ~pick_mask;
                    pairs_n    = pairs + 4'd1;
                    if (pairs_n == ALL_PAIRS || limit_hit) begin
                        game_over_n = 1'b1;
                        state_n     = DONE;
`ifdef MOVE_LIMIT_EN
                        won_n       = (pairs_n == ALL_PAIRS);
`endif
                    end else begin
                        state_n = PICK1;
                    end
                end else begin
                    tmr_load = 1'b1;
                    state_n  = SHOW;
                end
            end
            SHOW: begin
                if (tmr_zero) begin
                    revealed_n = revealed & ~pick_mask;
                    if (limit_hit) begin
                        game_over_n = 1'b1;
                        state_n     = DONE;
                    end else begin
                        state_n = PICK1;
                    end
                end
            end
            DONE:    game_over_n = 1'b1;
            default: state_n = IDLE;
        endcase
        // Leaving in-game mid-round abandons the board.
        if (in_play && !ingameOn) begin
            state_n    = IDLE;
            cursor_n   = '0;
            revealed_n = '0;
            matched_n  = '0;
            moves_n    = '0;
            pairs_n    = '0;
            first_n    = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (userquit) begin
            state      <= IDLE;
            free_cnt   <= '0;
            offset     <= '0;
            cursor     <= '0;
            revealed   <= '0;
            matched    <= '0;
            moves      <= '0;
            pairs      <= '0;
            first_idx  <= '0;
            second_idx <= '0;
            gameOver   <= 1'b0;
`ifdef MOVE_LIMIT_EN
            won        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            free_cnt   <= free_cnt + 4'd1;
            offset     <= offset_n;
            cursor     <= cursor_n;
            revealed   <= revealed_n;
            matched    <= matched_n;
            moves      <= moves_n;
            pairs      <= pairs_n;
            first_idx  <= first_n;
            second_idx <= second_n;
            gameOver   <= game_over_n;
`ifdef MOVE_LIMIT_EN
            won        <= won_n;
`endif
        end
    end

endmodule

// File: tb/tb_tile_match_engine.sv
// Directed scoreboard bench for tile_match_engine.
// Short mismatch hold so the reveal window is observable.
module tb_tile_match_engine;

    logic        clk = 1'b0;
    logic        userquit, ingameOn;
    logic        key_up, key_down, key_left, key_right, key_select;
    logic [3:0]  query_idx;
    logic [2:0]  query_val;
    logic [3:0]  cursor;
    logic [15:0] revealed, matched;
    logic [7:0]  moves;
    logic        gameOver;

    int checks = 0;
    int errors = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];
    int cur_r = 0;
    int cur_c = 0;
    logic [15:0] exp_mat;
    int exp_moves;
    int pa[5] = '{3, 4, 5, 6, 7};
    int pb[5] = '{8, 11, 14, 13, 10};

    always #5 clk = ~clk;

    tile_match_engine #(.MISMATCH_CYCLES(4), .MOVES_W(8)) dut (
        .CLOCK_50   (clk),
        .userquit   (userquit),
        .ingameOn   (ingameOn),
        .key_up     (key_up),
        .key_down   (key_down),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_select (key_select),
        .query_idx  (query_idx),
        .query_val  (query_val),
        .cursor     (cursor),
        .revealed   (revealed),
        .matched    (matched),
        .moves      (moves),
        .gameOver   (gameOver)
    );

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int k);
        key_up    = (k == 0);
        key_down  = (k == 1);
        key_left  = (k == 2);
        key_right = (k == 3);
        step(1);
        {key_up, key_down, key_left, key_right} = 4'b0;
        case (k)
            0: cur_r = (cur_r + 3) % 4;
            1: cur_r = (cur_r + 1) % 4;
            2: cur_c = (cur_c + 3) % 4;
            default: cur_c = (cur_c + 1) % 4;
        endcase
    endtask

    task automatic goto_tile(input int idx);
        for (int i = 0; i < 4 && cur_c != idx % 4; i++) press(3);
        for (int i = 0; i < 4 && cur_r != idx / 4; i++) press(1);
    endtask

    task automatic pick(input int idx);
        goto_tile(idx);
        key_select = 1'b1;
        step(1);
        key_select = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        userquit = 1'b1;
        ingameOn = 1'b0;
        {key_up, key_down, key_left, key_right, key_select} = 5'b0;
        query_idx = 4'd0;
        exp_mat = 16'h0;
        exp_moves = 0;
        step(3);
        expect_val("rst_cursor", 0);   check(cursor);
        expect_val("rst_revealed", 0); check(revealed);
        expect_val("rst_matched", 0);  check(matched);
        expect_val("rst_moves", 0);    check(moves);
        expect_val("rst_gameover", 0); check(gameOver);

        // Start with the free-running counter at 0, so offset is 0.
        userquit = 1'b0;
        ingameOn = 1'b1;
        step(1);
        expect_val("start_cursor", 0); check(cursor);
        expect_val("start_gameover", 0); check(gameOver);
        query_idx = 4'd0;  #1; expect_val("qv0", 3);  check(query_val);
        query_idx = 4'd9;  #1; expect_val("qv9", 3);  check(query_val);
        query_idx = 4'd12; #1; expect_val("qv12", 0); check(query_val);
        query_idx = 4'd15; #1; expect_val("qv15", 5); check(query_val);

        // Mismatch 0/1: four cycles of SHOW with both tiles up.
        pick(0);
        expect_val("mis_first", 16'h0001); check(revealed);
        pick(1);
        exp_moves++;
        expect_val("mis_second", 16'h0003); check(revealed);
        expect_val("mis_moves", exp_moves); check(moves);
        for (int i = 0; i < 4; i++) begin
            step(1);
            expect_val($sformatf("mis_show%0d", i), 16'h0003);
            check(revealed);
        end
        step(1);
        expect_val("mis_hidden", 0); check(revealed);
        expect_val("mis_matched", 0); check(matched);

        // Match 0/9 with latency check.
        pick(0);
        pick(9);
        exp_moves++;
        expect_val("m09_rev", 16'h0201); check(revealed);
        expect_val("m09_mat_early", 0);  check(matched);
        expect_val("m09_moves", exp_moves); check(moves);
        step(1);
        exp_mat = 16'h0201;
        expect_val("m09_mat", exp_mat); check(matched);
        expect_val("m09_rev_clr", 0);   check(revealed);

        // Reselecting the first tile or a matched tile is ignored.
        pick(1);
        pick(1);
        expect_val("resel_rev", 16'h0002); check(revealed);
        expect_val("resel_moves", exp_moves); check(moves);
        pick(0);
        expect_val("matched_sel_rev", 16'h0002); check(revealed);
        pick(12);
        exp_moves++;
        step(1);
        exp_mat |= 16'h1002;
        expect_val("m112_mat", exp_mat); check(matched);

        // Select and move together: old cursor tile is revealed.
        goto_tile(2);
        key_select = 1'b1;
        key_right  = 1'b1;
        step(1);
        key_select = 1'b0;
        key_right  = 1'b0;
        cur_c = 3;
        expect_val("selmove_rev", 16'h0004); check(revealed);
        expect_val("selmove_cur", cur_r * 4 + cur_c); check(cursor);
        pick(15);
        exp_moves++;
        step(1);
        exp_mat |= 16'h8004;
        expect_val("m215_mat", exp_mat); check(matched);

        // Cursor wrap and key priority.
        goto_tile(3);
        press(3);
        expect_val("wrap_right", 0); check(cursor);
        goto_tile(12);
        press(1);
        expect_val("wrap_down", 0); check(cursor);
        goto_tile(5);
        key_up   = 1'b1;
        key_left = 1'b1;
        step(1);
        key_up   = 1'b0;
        key_left = 1'b0;
        cur_r = 0;
        expect_val("prio_up_left", 1); check(cursor);

        // Remaining pairs; game over one cycle after the last compare.
        for (int p = 0; p < 5; p++) begin
            pick(pa[p]);
            pick(pb[p]);
            exp_moves++;
            expect_val($sformatf("pair%0d_moves", p), exp_moves); check(moves);
            expect_val($sformatf("pair%0d_go_pre", p), 0); check(gameOver);
            step(1);
            exp_mat |= (16'd1 << pa[p]) | (16'd1 << pb[p]);
            expect_val($sformatf("pair%0d_mat", p), exp_mat); check(matched);
        end
        expect_val("gameover_set", 1); check(gameOver);
        ingameOn = 1'b0;
        step(3);
        expect_val("gameover_hold", 1); check(gameOver);
        expect_val("done_matched", 16'hFFFF); check(matched);
        userquit = 1'b1;
        step(1);
        expect_val("gameover_clr", 0); check(gameOver);
        expect_val("quit_matched", 0); check(matched);

        // Abort while a mismatch is on display.
        userquit = 1'b0;
        ingameOn = 1'b1;
        cur_r = 0;
        cur_c = 0;
        step(1);
        pick(0);
        pick(9);
        step(1);
        expect_val("ab_mat", 16'h0201); check(matched);
        pick(1);
        pick(2);
        step(1);
        expect_val("ab_show_rev", 16'h0006); check(revealed);
        ingameOn = 1'b0;
        step(1);
        expect_val("ab_rev", 0); check(revealed);
        expect_val("ab_mat_clr", 0); check(matched);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
